// File: rtl/blob_centroid_tracker.sv
// Per-frame blob statistics: count, coordinate sums and bounding box, with a centroid from a sequential divide.
// Optional bounding-box tracking is compiled in when BLOB_BBOX_EN is defined; otherwise o_xmin/o_xmax/o_ymin/o_ymax read 0.
module blob_centroid_tracker #(
    parameter int IMG_W     = 800,
    parameter int IMG_H     = 600,
    parameter int MIN_COUNT = 16,
    parameter int CNTW      = 19,
    parameter int SUMW      = 29
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_fval,
    input  logic            i_valid,
    input  logic            i_bin,
    output logic            o_res_valid,
    output logic            o_found,
    output logic [9:0]      o_cx,
    output logic [9:0]      o_cy,
    output logic [CNTW-1:0] o_count,
    output logic [9:0]      o_xmin,
    output logic [9:0]      o_xmax,
    output logic [9:0]      o_ymin,
    output logic [9:0]      o_ymax,
    output logic            o_overrun
);
    localparam int ITW = $clog2(SUMW + 1);
    localparam logic [9:0] XLAST = 10'(IMG_W - 1);
    localparam logic [9:0] YLAST = 10'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
    state_t r_state;

    logic            r_fval, r_full, r_ovr, r_h_ovr;
    logic [9:0]      r_x, r_y;
    logic [CNTW-1:0] r_cnt, r_h_cnt, r_rx, r_ry;
    logic [SUMW-1:0] r_sumx, r_sumy, r_qx, r_qy;
    logic [ITW-1:0]  r_it;

    logic            w_rise, w_fall, w_full_n, w_ovr_n, w_okx, w_oky;
    logic [9:0]      w_x_n, w_y_n;
    logic [CNTW-1:0] w_cnt_n;
    logic [SUMW-1:0] w_sumx_n, w_sumy_n;
    logic [CNTW:0]   w_rxs, w_rys;

    assign w_rise = i_fval & ~r_fval;
    assign w_fall = ~i_fval & r_fval;

    // Frame start clears the accumulators in the same cycle a pixel may arrive.
    always_comb begin
        w_x_n    = w_rise ? '0 : r_x;
        w_y_n    = w_rise ? '0 : r_y;
        w_cnt_n  = w_rise ? '0 : r_cnt;
        w_sumx_n = w_rise ? '0 : r_sumx;
        w_sumy_n = w_rise ? '0 : r_sumy;
        w_full_n = w_rise ? 1'b0 : r_full;
        w_ovr_n  = w_rise ? 1'b0 : r_ovr;
        if (i_fval && i_valid) begin
            if (w_full_n) begin
                w_ovr_n = 1'b1;
            end else begin
                if (i_bin) begin
                    w_cnt_n  = w_cnt_n + CNTW'(1);
                    w_sumx_n = w_sumx_n + SUMW'(w_x_n);
                    w_sumy_n = w_sumy_n + SUMW'(w_y_n);
                end
                if (w_x_n == XLAST) begin
                    w_x_n = '0;
                    if (w_y_n == YLAST) w_full_n = 1'b1;
                    else                w_y_n = w_y_n + 10'd1;
                end else begin
                    w_x_n = w_x_n + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fval <= 1'b0; r_x <= '0; r_y <= '0; r_cnt <= '0;
            r_sumx <= '0; r_sumy <= '0; r_full <= 1'b0; r_ovr <= 1'b0;
        end else begin
            r_fval <= i_fval; r_x <= w_x_n; r_y <= w_y_n; r_cnt <= w_cnt_n;
            r_sumx <= w_sumx_n; r_sumy <= w_sumy_n; r_full <= w_full_n; r_ovr <= w_ovr_n;
        end
    end

`ifdef BLOB_BBOX_EN
    logic [9:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [9:0] r_h_xmin, r_h_xmax, r_h_ymin, r_h_ymax;
    logic [9:0] w_px, w_py, w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
    logic       w_hit;

    assign w_px     = w_rise ? 10'd0 : r_x;
    assign w_py     = w_rise ? 10'd0 : r_y;
    assign w_hit    = i_fval & i_valid & i_bin & ~(w_rise ? 1'b0 : r_full);
    assign w_xmin_b = w_rise ? 10'h3FF : r_xmin;
    assign w_xmax_b = w_rise ? 10'h000 : r_xmax;
    assign w_ymin_b = w_rise ? 10'h3FF : r_ymin;
    assign w_ymax_b = w_rise ? 10'h000 : r_ymax;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
        end else begin
            r_xmin <= (w_hit && w_px < w_xmin_b) ? w_px : w_xmin_b;
            r_xmax <= (w_hit && w_px > w_xmax_b) ? w_px : w_xmax_b;
            r_ymin <= (w_hit && w_py < w_ymin_b) ? w_py : w_ymin_b;
            r_ymax <= (w_hit && w_py > w_ymax_b) ? w_py : w_ymax_b;
        end
    end
`else
    assign o_xmin = '0;
    assign o_xmax = '0;
    assign o_ymin = '0;
    assign o_ymax = '0;
`endif

    // One restoring-division step per cycle for each axis; the divisor is the held count.
    assign w_rxs = {r_rx, r_qx[SUMW-1]};
    assign w_rys = {r_ry, r_qy[SUMW-1]};
    assign w_okx = w_rxs >= {1'b0, r_h_cnt};
    assign w_oky = w_rys >= {1'b0, r_h_cnt};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE; r_h_cnt <= '0; r_h_ovr <= 1'b0;
            r_qx <= '0; r_qy <= '0; r_rx <= '0; r_ry <= '0; r_it <= '0;
            o_res_valid <= 1'b0; o_found <= 1'b0; o_cx <= '0; o_cy <= '0;
            o_count <= '0; o_overrun <= 1'b0;
`ifdef BLOB_BBOX_EN
            r_h_xmin <= '0; r_h_xmax <= '0; r_h_ymin <= '0; r_h_ymax <= '0;
            o_xmin <= '0; o_xmax <= '0; o_ymin <= '0; o_ymax <= '0;
`endif
        end else begin
            o_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_fall) begin
                    r_h_cnt <= r_cnt; r_h_ovr <= r_ovr;
                    r_qx <= r_sumx; r_qy <= r_sumy; r_rx <= '0; r_ry <= '0;
                    r_it <= ITW'(SUMW - 1);
`ifdef BLOB_BBOX_EN
                    r_h_xmin <= r_xmin; r_h_xmax <= r_xmax;
                    r_h_ymin <= r_ymin; r_h_ymax <= r_ymax;
`endif
                    r_state <= (r_cnt >= CNTW'(MIN_COUNT)) ? S_DIV : S_DONE;
                end
                S_DIV: begin
                    r_rx <= w_okx ? CNTW'(w_rxs - {1'b0, r_h_cnt}) : CNTW'(w_rxs);
                    r_ry <= w_oky ? CNTW'(w_rys - {1'b0, r_h_cnt}) : CNTW'(w_rys);
                    r_qx <= {r_qx[SUMW-2:0], w_okx};
                    r_qy <= {r_qy[SUMW-2:0], w_oky};
                    r_it <= r_it - ITW'(1);
                    if (r_it == '0) r_state <= S_DONE;
                end
                S_DONE: begin
                    o_res_valid <= 1'b1;
                    o_count     <= r_h_cnt;
                    o_overrun   <= r_h_ovr;
                    o_found     <= (r_h_cnt >= CNTW'(MIN_COUNT));
                    o_cx        <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_qx[9:0] : 10'd0;
                    o_cy        <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_qy[9:0] : 10'd0;
`ifdef BLOB_BBOX_EN
                    o_xmin <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_h_xmin : 10'd0;
                    o_xmax <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_h_xmax : 10'd0;
                    o_ymin <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_h_ymin : 10'd0;
                    o_ymax <= (r_h_cnt >= CNTW'(MIN_COUNT)) ? r_h_ymax : 10'd0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
